param_regfile_mem: RTL and testbench
====================================

Name: param_regfile_mem

Overview:
- Parametrised register-file memory: one write port and one independent read port.
- Registered read with a valid strobe and write-first bypass.
- Per-entry written flags, a synchronous bulk clear, and a live count of written entries.
- Next-generation storage block for the lab datapath: drop-in for the 16x5 store, with wider, deeper configurations, no write/read address sharing, and occupancy tracking.

Parameters:
- DATA_WIDTH, 5, width of each stored word.
- ADDR_WIDTH, 4, address bits; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- RESET_VALUE, 0, value loaded into every entry and into data_out on reset/clear (DATA_WIDTH bits).

Ports:
- Clk  input  1  single clock; all state changes on rising edge except reset.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous bulk clear of all entries and flags.
- write_enable  input  1  write strobe.
- write_address  input  ADDR_WIDTH  write location.
- data_in  input  DATA_WIDTH  write data.
- read_enable  input  1  read strobe.
- read_address  input  ADDR_WIDTH  read location.
- data_out  output  DATA_WIDTH  registered read data; holds last value when no read.
- read_valid  output  1  one-cycle pulse, the cycle after an accepted read.
- read_hit  output  1  registered with data_out: 1 if the entry read had been written since last reset/clear.
- valid_count  output  ADDR_WIDTH+1  number of entries written since last reset/clear, 0..DEPTH.

Behaviour:
- Decided: one clock; reset is asynchronous and active-high; ports named Clk and reset.
- Reset (asynchronous, immediate, independent of Clk):
  - all entries = RESET_VALUE; all written flags = 0.
  - data_out = RESET_VALUE; read_valid = 0; read_hit = 0; valid_count = 0.
  - Reset mid-operation aborts any in-flight read: no read_valid pulse follows.
- Write: on the edge with write_enable=1 and clear=0:
  - entry[write_address] <= data_in; flag[write_address] <= 1.
  - valid_count increments by 1 only if the flag was previously 0. Rewriting an entry does not change the count.
- Read: on the edge with read_enable=1:
  - data_out <= entry[read_address]; read_hit <= flag[read_address]; read_valid <= 1.
  - Latency is exactly 1 cycle.
- No read: read_valid <= 0; data_out and read_hit hold.
- Write-first bypass: read_enable and write_enable both 1 with equal addresses (clear=0):
  - data_out <= data_in; read_hit <= 1.
- Clear: on the edge with clear=1:
  - all entries <= RESET_VALUE; all flags <= 0; valid_count <= 0.
  - A simultaneous write is dropped.
  - A simultaneous read is still accepted: data_out <= RESET_VALUE, read_hit <= 0, read_valid <= 1.
- Address range: full; every address < DEPTH. No wrap or out-of-range case exists.
- valid_count saturates naturally at DEPTH because it counts flags. It never exceeds DEPTH and never wraps.
- Storage is one flop per bit. No inferred RAM attributes, because reset/clear must touch every entry in one cycle.
- X on write_enable/read_enable outside reset is a bench error and need not be handled.

Test Plan:
- Reset then idle: assert reset between edges → outputs go 0 immediately; after release, valid_count=0, read_valid=0 for 5 idle cycles.
- Write/read basic (defaults): write 5'h1A to addr 3, next cycle read addr 3 → following cycle data_out=5'h1A, read_hit=1, read_valid=1; next idle cycle read_valid=0, data_out holds 5'h1A.
- Unwritten read and counting: write addrs 0,1,1,15 → valid_count=3; read addr 7 → data_out=0, read_hit=0.
- Fill: write all 16 addrs with value=addr → valid_count=16; read back all 16 in consecutive cycles → back-to-back read_valid, data_out=0..15 in order.
- Bypass and clear collision: write 5'h05 and read addr 9 same cycle (entry 9 previously 5'h11) → data_out=5'h05. Then clear + write addr 2 + read addr 9 same cycle → data_out=0, read_hit=0, valid_count=0, and a later read of addr 2 returns 0.
- Parametrised instance DATA_WIDTH=16, ADDR_WIDTH=6, RESET_VALUE=16'hDEAD: reset → read any addr gives 16'hDEAD, read_hit=0; write all 64 → valid_count=64 (7'b1000000); assert reset mid-read → no read_valid pulse follows.

Source files
------------

// File: rtl/param_regfile_mem.sv
// Parametrised register-file memory: one write port, one independent read
// port, registered read with valid strobe and write-first bypass, per-entry
// written flags, synchronous bulk clear and a live count of written entries.
module param_regfile_mem #(
  parameter int                    DATA_WIDTH  = 5,
  parameter int                    ADDR_WIDTH  = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  read_hit,
  output logic [ADDR_WIDTH:0]   valid_count
);

  // Depth follows from the address width and cannot be set independently.
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;

  logic                  write_accept;
  logic                  new_entry;
  logic                  bypass;
  logic [DATA_WIDTH-1:0] read_data_next;
  logic                  read_hit_next;

  // A clear on the same edge wins over any write.
  assign write_accept = write_enable && !clear;
  // Only the first write to an entry since reset/clear adds to the count.
  assign new_entry    = write_accept && !written[write_address];
  // Same-cycle write and read to one address returns the new data.
  assign bypass       = write_accept && (write_address == read_address);

  // Select the value a read captures this edge: clear, bypass or stored entry.
  always_comb begin
    // NOTE: defaults assigned first so every path drives both outputs and no latch is inferred.
    read_data_next = mem[read_address];
    read_hit_next  = written[read_address];
    if (clear) begin
      read_data_next = RESET_VALUE;
      read_hit_next  = 1'b0;
    end else if (bypass) begin
      read_data_next = data_in;
      read_hit_next  = 1'b1;
    end
  end

  // Storage array and written flags; reset and clear touch every entry at once.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      // NOTE: every entry is reset explicitly, which keeps this array in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
      written <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VALUE;
      end
      written <= '0;
    end else if (write_accept) begin
      // NOTE: non-blocking so the read logic on this edge still sees the pre-write contents.
      mem[write_address]     <= data_in;
      written[write_address] <= 1'b1;
    end
  end

  // Occupancy count: tracks the number of set flags, so it tops out at DEPTH.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      valid_count <= '0;
    end else if (clear) begin
      valid_count <= '0;
    end else if (new_entry) begin
      valid_count <= valid_count + {{ADDR_WIDTH{1'b0}}, 1'b1};
    end
  end

  // Registered read port: capture on read_enable, hold otherwise, pulse valid.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      data_out   <= RESET_VALUE;
      read_hit   <= 1'b0;
      read_valid <= 1'b0;
    end else if (read_enable) begin
      data_out   <= read_data_next;
      read_hit   <= read_hit_next;
      read_valid <= 1'b1;
    end else begin
      read_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_regfile_mem.sv
// Self-checking bench for param_regfile_mem: a default 16x5 instance driven
// from vector tables with a read scoreboard, and a 64x16 instance with a
// non-zero reset value exercised by hand-written sequences.
module tb_param_regfile_mem;

  logic clk;

  // Default instance signals.
  logic       reset, clear, we, re;
  logic [3:0] wa, ra;
  logic [4:0] din, dout;
  logic       rv, rh;
  logic [4:0] vc;

  // Wide instance signals.
  logic        reset_b, clear_b, we_b, re_b;
  logic [5:0]  wa_b, ra_b;
  logic [15:0] din_b, dout_b;
  logic        rv_b, rh_b;
  logic [6:0]  vc_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       clr;
    logic       we;
    logic [3:0] wa;
    logic [4:0] din;
    logic       re;
    logic [3:0] ra;
    logic [4:0] exp_data;
    logic       exp_hit;
    logic [4:0] exp_count;
  } vec_t;

  typedef struct packed {
    logic [4:0] data;
    logic       hit;
  } rd_t;

  rd_t  sb_q[$];
  vec_t tbl_a[$];
  vec_t tbl_b[$];

  param_regfile_mem dut (
    .Clk           (clk),
    .reset         (reset),
    .clear         (clear),
    .write_enable  (we),
    .write_address (wa),
    .data_in       (din),
    .read_enable   (re),
    .read_address  (ra),
    .data_out      (dout),
    .read_valid    (rv),
    .read_hit      (rh),
    .valid_count   (vc)
  );

  param_regfile_mem #(
    .DATA_WIDTH  (16),
    .ADDR_WIDTH  (6),
    .RESET_VALUE (16'hDEAD)
  ) dut_b (
    .Clk           (clk),
    .reset         (reset_b),
    .clear         (clear_b),
    .write_enable  (we_b),
    .write_address (wa_b),
    .data_in       (din_b),
    .read_enable   (re_b),
    .read_address  (ra_b),
    .data_out      (dout_b),
    .read_valid    (rv_b),
    .read_hit      (rh_b),
    .valid_count   (vc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic clr_i, input logic we_i, input logic [3:0] wa_i,
                              input logic [4:0] din_i, input logic re_i, input logic [3:0] ra_i,
                              input logic [4:0] ed, input logic eh, input logic [4:0] ec);
    vec_t v;
    v.clr = clr_i; v.we = we_i; v.wa = wa_i; v.din = din_i;
    v.re = re_i; v.ra = ra_i;
    v.exp_data = ed; v.exp_hit = eh; v.exp_count = ec;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one vector for one edge; reads go through the scoreboard, idle
  // cycles check that data_out/read_hit hold.
  task automatic apply(input vec_t v);
    rd_t e;
    clear = v.clr; we = v.we; wa = v.wa; din = v.din; re = v.re; ra = v.ra;
    if (v.re) sb_q.push_back('{data: v.exp_data, hit: v.exp_hit});
    tick();
    check("read_valid", 32'(rv), 32'(v.re));
    if (v.re) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: got read, expected queue entry");
      end else begin
        e = sb_q.pop_front();
        check("read_data", 32'(dout), 32'(e.data));
        check("read_hit", 32'(rh), 32'(e.hit));
      end
    end else begin
      check("hold_data", 32'(dout), 32'(v.exp_data));
      check("hold_hit", 32'(rh), 32'(v.exp_hit));
    end
    check("valid_count", 32'(vc), 32'(v.exp_count));
    clear = 0; we = 0; re = 0;
  endtask

  initial begin
    // Basic write/read, clear, unwritten reads and counting.
    //                 clr we wa     din    re ra     data   hit cnt
    tbl_a.push_back(mk(0, 1, 4'd3,  5'h1A, 0, 4'd0,  5'h00, 0, 5'd1));
    tbl_a.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd3,  5'h1A, 1, 5'd1));
    tbl_a.push_back(mk(0, 0, 4'd0,  5'h00, 0, 4'd0,  5'h1A, 1, 5'd1));
    tbl_a.push_back(mk(1, 0, 4'd0,  5'h00, 0, 4'd0,  5'h1A, 1, 5'd0));
    tbl_a.push_back(mk(0, 1, 4'd0,  5'h04, 0, 4'd0,  5'h1A, 1, 5'd1));
    tbl_a.push_back(mk(0, 1, 4'd1,  5'h07, 0, 4'd0,  5'h1A, 1, 5'd2));
    tbl_a.push_back(mk(0, 1, 4'd1,  5'h08, 0, 4'd0,  5'h1A, 1, 5'd2));
    tbl_a.push_back(mk(0, 1, 4'd15, 5'h0F, 0, 4'd0,  5'h1A, 1, 5'd3));
    tbl_a.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd7,  5'h00, 0, 5'd3));
    tbl_a.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd1,  5'h08, 1, 5'd3));
    tbl_a.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd3,  5'h00, 0, 5'd3));
    // Bypass and clear collisions, starting from a full array holding value=addr.
    tbl_b.push_back(mk(0, 1, 4'd9,  5'h11, 0, 4'd0,  5'h0F, 1, 5'd16));
    tbl_b.push_back(mk(0, 1, 4'd9,  5'h05, 1, 4'd9,  5'h05, 1, 5'd16));
    tbl_b.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd9,  5'h05, 1, 5'd16));
    tbl_b.push_back(mk(1, 1, 4'd2,  5'h1F, 1, 4'd9,  5'h00, 0, 5'd0));
    tbl_b.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd2,  5'h00, 0, 5'd0));
    tbl_b.push_back(mk(0, 1, 4'd4,  5'h0A, 1, 4'd5,  5'h00, 0, 5'd1));
    tbl_b.push_back(mk(0, 0, 4'd0,  5'h00, 1, 4'd4,  5'h0A, 1, 5'd1));
    tbl_b.push_back(mk(0, 0, 4'd0,  5'h00, 0, 4'd0,  5'h0A, 1, 5'd1));

    reset = 1; clear = 0; we = 0; re = 0; wa = '0; ra = '0; din = '0;
    reset_b = 1; clear_b = 0; we_b = 0; re_b = 0; wa_b = '0; ra_b = '0; din_b = '0;
    #1;
    check("reset_data", 32'(dout), 32'h0);
    check("reset_valid", 32'(rv), 32'h0);
    check("reset_hit", 32'(rh), 32'h0);
    check("reset_count", 32'(vc), 32'h0);
    check("b_reset_data", 32'(dout_b), 32'hDEAD);
    repeat (2) @(negedge clk);
    reset = 0; reset_b = 0;

    // Idle after reset release.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_valid", 32'(rv), 32'h0);
      check("idle_count", 32'(vc), 32'h0);
    end

    foreach (tbl_a[i]) apply(tbl_a[i]);

    // Fill every entry with its own address, then read all back-to-back.
    apply(mk(1, 0, 4'd0, 5'h00, 0, 4'd0, 5'h00, 0, 5'd0));
    for (int i = 0; i < 16; i++)
      apply(mk(0, 1, 4'(i), 5'(i), 0, 4'd0, 5'h00, 0, 5'(i + 1)));
    for (int i = 0; i < 16; i++) begin
      rd_t e;
      clear = 0; we = 0; re = 1; ra = 4'(i);
      sb_q.push_back('{data: 5'(i), hit: 1'b1});
      tick();
      check("fill_valid", 32'(rv), 32'h1);
      e = sb_q.pop_front();
      check("fill_data", 32'(dout), 32'(e.data));
      check("fill_hit", 32'(rh), 32'(e.hit));
    end
    re = 0;
    check("fill_count", 32'(vc), 32'd16);

    foreach (tbl_b[i]) apply(tbl_b[i]);

    // Reset asserted between edges right after an accepted read.
    re = 1; ra = 4'd4;
    @(posedge clk);
    #2;
    check("pre_reset_valid", 32'(rv), 32'h1);
    check("pre_reset_data", 32'(dout), 32'h0A);
    reset = 1;
    #1;
    check("async_reset_data", 32'(dout), 32'h0);
    check("async_reset_valid", 32'(rv), 32'h0);
    check("async_reset_hit", 32'(rh), 32'h0);
    check("async_reset_count", 32'(vc), 32'h0);
    @(negedge clk);
    re = 0; reset = 0;
    tick();
    check("post_reset_valid", 32'(rv), 32'h0);
    apply(mk(0, 0, 4'd0, 5'h00, 1, 4'd4, 5'h00, 0, 5'd0));

    // Wide instance: reset value reads, full fill, reset during a read.
    re_b = 1; ra_b = 6'd37;
    tick();
    re_b = 0;
    check("b_read_valid", 32'(rv_b), 32'h1);
    check("b_read_reset_value", 32'(dout_b), 32'hDEAD);
    check("b_read_hit", 32'(rh_b), 32'h0);
    for (int i = 0; i < 64; i++) begin
      we_b = 1; wa_b = 6'(i); din_b = 16'h1000 + 16'(i);
      tick();
    end
    we_b = 0;
    check("b_full_count", 32'(vc_b), 32'd64);
    we_b = 1; wa_b = 6'd10; din_b = 16'hBEEF;
    tick();
    we_b = 0;
    check("b_rewrite_count", 32'(vc_b), 32'd64);
    re_b = 1; ra_b = 6'd63;
    tick();
    re_b = 0;
    check("b_read63_data", 32'(dout_b), 32'h103F);
    check("b_read63_hit", 32'(rh_b), 32'h1);
    re_b = 1; ra_b = 6'd5;
    #2;
    reset_b = 1;
    #1;
    check("b_reset_mid_valid", 32'(rv_b), 32'h0);
    check("b_reset_mid_data", 32'(dout_b), 32'hDEAD);
    check("b_reset_mid_count", 32'(vc_b), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("b_reset_edge_valid", 32'(rv_b), 32'h0);
    re_b = 0; reset_b = 0;
    tick();
    check("b_no_pulse_valid", 32'(rv_b), 32'h0);
    re_b = 1; ra_b = 6'd5;
    tick();
    re_b = 0;
    check("b_after_reset_data", 32'(dout_b), 32'hDEAD);
    check("b_after_reset_hit", 32'(rh_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
